dual_port_ram_be: RTL and testbench

- Parametrised simple dual-port RAM: one write port, one read port, single clock. Successor to the basic M9K-style dual-port RAM.
- Adds per-byte write enables, qualified reads with a valid flag, and a selectable read-during-write mode.
- Adds a configurable read latency of 1 or 2 and a post-reset clear sequencer.
- Used for register files, scratchpads and FIFO storage inside the MCU.

---
 rtl/mcu_mem_pkg.sv | 22 ++
 rtl/dual_port_ram_be_if.sv | 36 +++
 rtl/dual_port_ram_be_core.sv | 47 ++++
 rtl/dual_port_ram_be.sv | 191 +++++++++++++++++++
 tb/tb_dual_port_ram_be.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_mem_pkg.sv
// rtl/mcu_mem_pkg.sv - shared types and helpers for the MCU memory blocks
//
// Purpose: clear-sequencer state encoding, read-during-write mode constants
// and a byte-lane count helper shared by the RAM top, core and interface.
// Ports: none (package).

package mcu_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_READY_WAIT = 2'd1,
    ST_RUN        = 2'd2
  } mem_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dual_port_ram_be_if.sv
// rtl/dual_port_ram_be_if.sv - write/read port bundle for dual_port_ram_be
//
// Purpose: groups the write port, read port and status outputs of the RAM.
// Ports (signals):
//   waddr, din, write_en, byte_en : write port (master -> slave)
//   raddr, read_en                : read port  (master -> slave)
//   dout, dout_valid, init_done   : read data and status (slave -> master)

interface dual_port_ram_be_if
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]                  waddr;
  logic [DATA_WIDTH-1:0]                  din;
  logic                                   write_en;
  logic [lane_count(DATA_WIDTH)-1:0]      byte_en;
  logic [ADDR_WIDTH-1:0]                  raddr;
  logic                                   read_en;
  logic [DATA_WIDTH-1:0]                  dout;
  logic                                   dout_valid;
  logic                                   init_done;

  modport master (
    output waddr, din, write_en, byte_en, raddr, read_en,
    input  dout, dout_valid, init_done
  );

  modport slave (
    input  waddr, din, write_en, byte_en, raddr, read_en,
    output dout, dout_valid, init_done
  );

endinterface

// File: rtl/dual_port_ram_be_core.sv
// rtl/dual_port_ram_be_core.sv - byte-enabled storage array with registered read
//
// Purpose: plain simple-dual-port array. No reset and no forwarding so the
// array maps onto block RAM; a same-edge read of a written word returns the
// pre-write contents.
// Ports:
//   clk            : clock
//   we, waddr      : write strobe and address
//   wdata, wbe     : write data and per-byte enables
//   re, raddr      : read strobe and address
//   rdata          : registered read data, holds between reads

module dual_port_ram_be_core
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wbe,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// rtl/dual_port_ram_be.sv - byte-enabled simple dual-port RAM with clear sequencer
//
// Purpose: one write port and one read port on a single clock, with per-byte
// write enables, read valid flag, selectable read-during-write behaviour,
// read latency of 1 or 2 and an optional post-reset clear of every word.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : dual_port_ram_be_if.slave (write port, read port, dout,
//           dout_valid, init_done)

module dual_port_ram_be
  import mcu_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    RDW_NEW_DATA   = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic               clk,
  input  logic               reset,
  dual_port_ram_be_if.slave  bus
);

  localparam int                    LANES     = lane_count(DATA_WIDTH);
  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dual_port_ram_be: READ_LATENCY must be 1 or 2");
  end

  mem_state_t            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  init_done_q;

  logic                  user_wr;
  logic                  user_rd;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [LANES-1:0]      mem_wbe;
  logic [DATA_WIDTH-1:0] core_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  rd_v1;

  // Clear sequencer: one word per cycle, init_done set on the edge that
  // writes the last address. RUN is terminal until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY_WAIT;
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state       <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_READY_WAIT: begin
          state       <= ST_RUN;
          init_done_q <= 1'b1;
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state       <= ST_READY_WAIT;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.init_done = init_done_q;

  // User traffic is only accepted once the RAM is ready.
  assign user_wr = init_done_q && bus.write_en && (|bus.byte_en);
  assign user_rd = init_done_q && bus.read_en;

  // Write port mux: the sequencer owns the port while clearing.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.waddr;
    mem_wdata = bus.din;
    mem_wbe   = bus.byte_en;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = INIT_VALUE;
      mem_wbe   = '1;
    end else if (user_wr) begin
      mem_we = 1'b1;
    end
  end

  dual_port_ram_be_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .wbe   (mem_wbe),
    .re    (user_rd),
    .raddr (bus.raddr),
    .rdata (core_q)
  );

  // The array always returns pre-write data on a collision; new-data mode
  // captures the colliding write lanes alongside the read and patches them
  // over the array output. These registers track the array's read register,
  // so like the array they carry no reset.
  if (RDW_NEW_DATA == RDW_NEW) begin : g_rdw_new
    logic [LANES-1:0]      fwd_mask;
    logic [DATA_WIDTH-1:0] fwd_data;

    always_ff @(posedge clk) begin
      if (user_rd) begin
        fwd_mask <= (user_wr && (bus.waddr == bus.raddr)) ? bus.byte_en : '0;
        fwd_data <= bus.din;
      end
    end

    always_comb begin
      merged = core_q;
      for (int i = 0; i < LANES; i++) begin
        if (fwd_mask[i]) begin
          merged[8*i +: 8] = fwd_data[8*i +: 8];
        end
      end
    end
  end else begin : g_rdw_old
    assign merged = core_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= user_rd;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rd_v2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
        rd_v2  <= 1'b0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) begin
          dout_q <= merged;
        end
      end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = rd_v2;
  end else begin : g_lat1
    // The array register is not reset, so dout is forced to zero until the
    // first read after reset; afterwards the array and forwarding registers
    // only change on a read, which keeps dout stable between reads.
    logic have_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        have_data <= 1'b0;
      end else if (user_rd) begin
        have_data <= 1'b1;
      end
    end

    assign bus.dout       = have_data ? merged : '0;
    assign bus.dout_valid = rd_v1;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb/tb_dual_port_ram_be.sv - scoreboard bench for dual_port_ram_be

module tb_dual_port_ram_be;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b0;
  logic [AW-1:0] waddr    = '0;
  logic [AW-1:0] raddr    = '0;
  logic [DW-1:0] din      = '0;
  logic          write_en = 1'b0;
  logic          read_en  = 1'b0;
  logic [3:0]    byte_en  = '0;

  dual_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
  dual_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();
  dual_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_c ();

  assign {if_a.waddr, if_a.din, if_a.write_en, if_a.byte_en, if_a.raddr, if_a.read_en} =
         {waddr, din, write_en, byte_en, raddr, read_en};
  assign {if_b.waddr, if_b.din, if_b.write_en, if_b.byte_en, if_b.raddr, if_b.read_en} =
         {waddr, din, write_en, byte_en, raddr, read_en};
  assign {if_c.waddr, if_c.din, if_c.write_en, if_c.byte_en, if_c.raddr, if_c.read_en} =
         {waddr, din, write_en, byte_en, raddr, read_en};

  // A: latency 1, old data, clear. B: latency 2, new data, clear.
  // C: latency 1, old data, no clear.
  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_NEW_DATA(0),
                     .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0))
    u_a (.clk(clk), .reset(reset), .bus(if_a));
  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_NEW_DATA(1),
                     .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  dual_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_NEW_DATA(0),
                     .CLEAR_ON_RESET(0), .INIT_VALUE(32'h0))
    u_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [DW-1:0] dout_w  [3];
  logic          valid_w [3];
  logic          done_w  [3];
  assign dout_w[0] = if_a.dout;  assign valid_w[0] = if_a.dout_valid;  assign done_w[0] = if_a.init_done;
  assign dout_w[1] = if_b.dout;  assign valid_w[1] = if_b.dout_valid;  assign done_w[1] = if_b.init_done;
  assign dout_w[2] = if_c.dout;  assign valid_w[2] = if_c.dout_valid;  assign done_w[2] = if_c.init_done;

  typedef struct {
    logic [DW-1:0] data;
    bit            known;
    int            due;
  } exp_t;

  int    lat [3] = '{1, 2, 1};
  int    rdw [3] = '{0, 1, 0};
  int    thr [3] = '{32, 32, 1};   // edges after release before traffic is accepted
  string nm  [3] = '{"A", "B", "C"};

  logic [DW-1:0] mem_m  [3][DEPTH];
  bit            known  [3][DEPTH];
  exp_t          sb     [3][$];
  logic [DW-1:0] last_d [3];
  bit            last_k [3];

  int cyc      = 0;
  int edges    = 0;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    bit   exp_v;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        check_eq($sformatf("%s rst dout", nm[d]), dout_w[d], '0);
        check_eq($sformatf("%s rst valid", nm[d]), DW'(valid_w[d]), '0);
        check_eq($sformatf("%s rst init_done", nm[d]), DW'(done_w[d]), '0);
      end else begin
        check_eq($sformatf("%s init_done", nm[d]), DW'(done_w[d]), DW'(edges >= thr[d]));
        exp_v = (sb[d].size() > 0) && (sb[d][0].due == cyc);
        check_eq($sformatf("%s dout_valid", nm[d]), DW'(valid_w[d]), DW'(exp_v));
        if (exp_v) begin
          e = sb[d].pop_front();
          if (e.known) check_eq($sformatf("%s dout", nm[d]), dout_w[d], e.data);
          last_d[d] = e.data;
          last_k[d] = e.known;
        end else if (last_k[d]) begin
          check_eq($sformatf("%s dout hold", nm[d]), dout_w[d], last_d[d]);
        end
      end
    end
  endtask

  // Model the coming edge from the current inputs, then clock and check.
  task automatic tick();
    exp_t e;
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (edges >= thr[d]) begin
          if (read_en) begin
            e.data  = mem_m[d][raddr];
            e.known = known[d][raddr];
            if (rdw[d] == 1 && write_en && waddr == raddr) begin
              for (int i = 0; i < 4; i++)
                if (byte_en[i]) e.data[8*i +: 8] = din[8*i +: 8];
            end
            e.due = cyc + lat[d];
            sb[d].push_back(e);
          end
          if (write_en) begin
            for (int i = 0; i < 4; i++)
              if (byte_en[i]) mem_m[d][waddr][8*i +: 8] = din[8*i +: 8];
            if (byte_en == 4'hF) known[d][waddr] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (!reset) begin
      edges++;
      for (int d = 0; d < 3; d++) begin
        if (thr[d] == 32 && edges == 32) begin
          for (int a = 0; a < DEPTH; a++) begin
            mem_m[d][a] = '0;
            known[d][a] = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("%s async dout", nm[d]), dout_w[d], '0);
      check_eq($sformatf("%s async valid", nm[d]), DW'(valid_w[d]), '0);
      check_eq($sformatf("%s async init_done", nm[d]), DW'(done_w[d]), '0);
      sb[d].delete();
      last_d[d] = '0;
      last_k[d] = 1'b1;
    end
    repeat (hold) tick();
    reset = 1'b0;
    edges = 0;
  endtask

  task automatic io(input bit we, input int wa, input logic [DW-1:0] d, input logic [3:0] be,
                    input bit re, input int ra);
    write_en = we;
    waddr    = AW'(wa);
    din      = d;
    byte_en  = be;
    read_en  = re;
    raddr    = AW'(ra);
    tick();
  endtask

  task automatic hold_through_clear();
    for (int i = 0; i < 32; i++) io(1'b1, i, $urandom, 4'hF, 1'b1, $urandom_range(0, 31));
    for (int i = 0; i < 32; i++) io(1'b0, 0, '0, 4'h0, 1'b1, i);
    repeat (3) io(1'b0, 0, '0, 4'h0, 1'b0, 0);
  endtask

  initial begin
    #2;
    do_reset(2);

    // Traffic held on during the clear window must be ignored, then all words read back.
    hold_through_clear();

    // Byte-lane merge: 0x11223344 then 0xAABBCCDD on lanes 0 and 2.
    io(1'b1, 3, 32'h11223344, 4'hF, 1'b0, 0);
    io(1'b1, 3, 32'hAABBCCDD, 4'h5, 1'b0, 0);
    io(1'b1, 3, 32'hFFFFFFFF, 4'h0, 1'b0, 0);
    io(1'b0, 0, '0, 4'h0, 1'b1, 3);
    repeat (3) io(1'b0, 0, '0, 4'h0, 1'b0, 0);

    // Back-to-back reads of 1, 2, 3.
    io(1'b1, 1, 32'hA, 4'hF, 1'b0, 0);
    io(1'b1, 2, 32'hB, 4'hF, 1'b0, 0);
    io(1'b1, 3, 32'hC, 4'hF, 1'b0, 0);
    io(1'b0, 0, '0, 4'h0, 1'b1, 1);
    io(1'b0, 0, '0, 4'h0, 1'b1, 2);
    io(1'b0, 0, '0, 4'h0, 1'b1, 3);
    repeat (3) io(1'b0, 0, '0, 4'h0, 1'b0, 0);

    // Read-during-write at address 7, then a plain read of the result.
    io(1'b1, 7, 32'h0, 4'hF, 1'b0, 0);
    io(1'b1, 7, 32'hFFFF0000, 4'hC, 1'b1, 7);
    io(1'b0, 0, '0, 4'h0, 1'b1, 7);
    repeat (3) io(1'b0, 0, '0, 4'h0, 1'b0, 0);

    // Random traffic, biased toward same-address collisions.
    for (int i = 0; i < 150; i++) begin
      int wa;
      wa = $urandom_range(0, 31);
      io(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom),
         ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31));
    end
    // Leave reads in flight, then reset on top of them.
    io(1'b0, 0, '0, 4'h0, 1'b1, 5);
    do_reset(1);

    // Reset again at clear count 10 with a read just accepted by C.
    for (int i = 0; i < 9; i++) io(1'b0, 0, '0, 4'h0, 1'b0, 0);
    io(1'b0, 0, '0, 4'h0, 1'b1, 31);
    do_reset(1);

    hold_through_clear();

    // Full-word write and readback at the top address.
    io(1'b1, 31, 32'hDEADBEEF, 4'hF, 1'b0, 0);
    io(1'b0, 0, '0, 4'h0, 1'b1, 31);
    repeat (4) io(1'b0, 0, '0, 4'h0, 1'b0, 0);

    for (int d = 0; d < 3; d++)
      check_eq($sformatf("%s drained", nm[d]), DW'(sb[d].size()), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
